shift_result_stage: RTL and testbench

//  Registered, flow-controlled stage directly downstream of the 16-bit combinational shifter.

---
 rtl/shift_stage_pkg.sv | 57 +++++
 rtl/shift_result_stage_sat_counter.sv | 38 +++
 rtl/shift_result_stage.sv | 101 ++++++++++
 tb/tb_shift_result_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_stage_pkg.sv
// ------------------------------------------------------------------
// shift_stage_pkg : control codes, entry record and capture helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package shift_stage_pkg;

    localparam int SHIFT_DATA_W = 16;
    localparam int SHIFT_RD_W   = 3;

    localparam logic [1:0] SHIFT_CTRL_PASS = 2'b00;
    localparam logic [1:0] SHIFT_CTRL_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_CTRL_SRL  = 2'b11;
    localparam logic [1:0] SHIFT_CTRL_RSVD = 2'b10;

    typedef struct packed {
        logic                    valid;
        logic [SHIFT_DATA_W-1:0] result;
        logic [SHIFT_RD_W-1:0]   rd;
        logic                    illegal;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
        logic                    zero;
`endif
    } entry_t;

    // The reserved code leaves the shifter output stale, so it is replaced by zero.
    function automatic entry_t make_entry(input logic [1:0]              ctrl,
                                          input logic [SHIFT_DATA_W-1:0] result,
                                          input logic [SHIFT_RD_W-1:0]   rd);
        entry_t e;
        e       = '0;
        e.valid = 1'b1;
        e.rd    = rd;
        case (ctrl)
            SHIFT_CTRL_PASS, SHIFT_CTRL_SLL, SHIFT_CTRL_SRL: begin
                e.result  = result;
                e.illegal = 1'b0;
            end
            SHIFT_CTRL_RSVD: begin
                e.result  = '0;
                e.illegal = 1'b1;
            end
            default: begin
                e.result  = '0;
                e.illegal = 1'b1;
            end
        endcase
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
        e.zero = (e.result == '0);
`endif
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_result_stage_sat_counter.sv
// ------------------------------------------------------------------
// sat_counter : W-bit up counter that sticks at its maximum value
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/shift_result_stage.sv
// ------------------------------------------------------------------
// shift_result_stage : 2-entry skid-buffered register stage after the shifter.
// Optional out_zero flag under SHIFT_STAGE_ZERO_FLAG_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module shift_result_stage
    import shift_stage_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int RD_W   = SHIFT_RD_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [1:0]        in_shift_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_illegal,
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    output logic              out_zero,
`endif
    output logic [CNT_W-1:0]  illegal_cnt
);

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   pop;

    assign new_entry = make_entry(in_shift_ctrl, in_result, in_rd);
    assign accept    = in_valid & in_ready_q;
    assign pop       = head_q.valid & out_ready;

    // in_ready is registered and equals "skid empty" after every edge.
    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
        if (flush) begin
            head_d.valid = 1'b0;
            skid_d.valid = 1'b0;
            in_ready_d   = 1'b1;
        end else if (!skid_q.valid) begin
            if (accept && (!head_q.valid || pop)) begin
                head_d = new_entry;
            end else if (accept) begin
                skid_d     = new_entry;
                in_ready_d = 1'b0;
            end else if (pop) begin
                head_d.valid = 1'b0;
            end
        end else if (pop) begin
            head_d       = skid_q;
            skid_d.valid = 1'b0;
            in_ready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_illegal_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept & new_entry.illegal & ~flush),
        .count (illegal_cnt)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = head_q.valid;
    assign out_result  = head_q.result;
    assign out_rd      = head_q.rd;
    assign out_illegal = head_q.illegal;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    assign out_zero    = head_q.zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_result_stage.sv
// ------------------------------------------------------------------
// tb_shift_result_stage : vector table, directed sequences and random traffic vs a queue model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_shift_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [1:0]  in_shift_ctrl = '0;
    logic [2:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    shift_result_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_shift_ctrl (in_shift_ctrl),
        .in_rd         (in_rd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_illegal   (out_illegal),
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
        .out_zero      (out_zero),
`endif
        .illegal_cnt   (illegal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Behavioural model: ordered queue of at most two entries.
    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        ill;
        logic        zero;
    } mentry_t;

    mentry_t mq[$];
    bit      m_rdy = 1'b1;
    int      m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdy = 1'b1;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit      acc;
        bit      pop;
        mentry_t e;
        if (flush) begin
            mq.delete();
            m_rdy = 1'b1;
        end else begin
            acc = in_valid && m_rdy;
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.ill  = (in_shift_ctrl == 2'b10);
                e.res  = e.ill ? 16'h0000 : in_result;
                e.rd   = in_rd;
                e.zero = (e.res == 16'h0000);
                mq.push_back(e);
                if (e.ill && m_cnt < 255) m_cnt++;
            end
            m_rdy = (mq.size() < 2);
        end
    endtask

    task automatic check_model();
        chk("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("model in_ready", 32'(in_ready), 32'(m_rdy));
        chk("model illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        if (mq.size() > 0) begin
            chk("model out_result", 32'(out_result), 32'(mq[0].res));
            chk("model out_rd", 32'(out_rd), 32'(mq[0].rd));
            chk("model out_illegal", 32'(out_illegal), 32'(mq[0].ill));
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
            chk("model out_zero", 32'(out_zero), 32'(mq[0].zero));
`endif
        end
    endtask

    // One clock: inputs already driven; sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic drive(input logic iv, input logic [15:0] res, input logic [1:0] ctrl,
                         input logic [2:0] rd, input logic ordy, input logic fl);
        in_valid      = iv;
        in_result     = res;
        in_shift_ctrl = ctrl;
        in_rd         = rd;
        out_ready     = ordy;
        flush         = fl;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] res;
        logic [1:0]  ctrl;
        logic [2:0]  rd;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [15:0] eres;
        logic        eill;
        logic        ez;
        logic        erdy;
        logic [7:0]  ecnt;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [15:0] res, input logic [1:0] ctrl,
                                input logic [2:0] rd, input logic ordy, input logic fl,
                                input logic ev, input logic [15:0] eres, input logic eill,
                                input logic ez, input logic erdy, input logic [7:0] ecnt);
        vec_t v;
        v.iv = iv; v.res = res; v.ctrl = ctrl; v.rd = rd; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.eres = eres; v.eill = eill; v.ez = ez; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // backpressure: third offer refused, then drain in order
        tbl[0]  = mk(1, 16'h00A5, 2'b00, 3'd1, 0, 0,  1, 16'h00A5, 0, 0, 1, 8'd0);
        tbl[1]  = mk(1, 16'h5A00, 2'b01, 3'd2, 0, 0,  1, 16'h00A5, 0, 0, 0, 8'd0);
        tbl[2]  = mk(1, 16'hFFFF, 2'b11, 3'd3, 0, 0,  1, 16'h00A5, 0, 0, 0, 8'd0);
        tbl[3]  = mk(0, 16'h0000, 2'b00, 3'd0, 1, 0,  1, 16'h5A00, 0, 0, 1, 8'd0);
        tbl[4]  = mk(0, 16'h0000, 2'b00, 3'd0, 1, 0,  0, 16'h0000, 0, 0, 1, 8'd0);
        // reserved control
        tbl[5]  = mk(1, 16'h1234, 2'b10, 3'd5, 0, 0,  1, 16'h0000, 1, 1, 1, 8'd1);
        tbl[6]  = mk(0, 16'h0000, 2'b00, 3'd0, 1, 0,  0, 16'h0000, 0, 0, 1, 8'd1);
        // flush with both entries full, then flush beating an accept
        tbl[7]  = mk(1, 16'h0011, 2'b01, 3'd1, 0, 0,  1, 16'h0011, 0, 0, 1, 8'd1);
        tbl[8]  = mk(1, 16'h0022, 2'b11, 3'd2, 0, 0,  1, 16'h0011, 0, 0, 0, 8'd1);
        tbl[9]  = mk(1, 16'h0033, 2'b10, 3'd3, 0, 1,  0, 16'h0000, 0, 0, 1, 8'd1);
        tbl[10] = mk(1, 16'h0044, 2'b10, 3'd4, 1, 1,  0, 16'h0000, 0, 0, 1, 8'd1);
        tbl[11] = mk(0, 16'h0000, 2'b00, 3'd0, 1, 0,  0, 16'h0000, 0, 0, 1, 8'd1);
        // zero flag
        tbl[12] = mk(1, 16'h0000, 2'b00, 3'd6, 1, 0,  1, 16'h0000, 0, 1, 1, 8'd1);
        tbl[13] = mk(1, 16'h8000, 2'b01, 3'd7, 1, 0,  1, 16'h8000, 0, 0, 1, 8'd1);
        tbl[14] = mk(0, 16'h0000, 2'b00, 3'd0, 1, 0,  0, 16'h0000, 0, 0, 1, 8'd1);

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_result", 32'(out_result), 32'd0);
        chk("reset out_rd", 32'(out_rd), 32'd0);
        chk("reset out_illegal", 32'(out_illegal), 32'd0);
        chk("reset illegal_cnt", 32'(illegal_cnt), 32'd0);
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
        chk("reset out_zero", 32'(out_zero), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].iv, tbl[i].res, tbl[i].ctrl, tbl[i].rd, tbl[i].ordy, tbl[i].fl);
            step();
            chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
            chk($sformatf("tbl[%0d] illegal_cnt", i), 32'(illegal_cnt), 32'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                chk($sformatf("tbl[%0d] out_result", i), 32'(out_result), 32'(tbl[i].eres));
                chk($sformatf("tbl[%0d] out_illegal", i), 32'(out_illegal), 32'(tbl[i].eill));
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
                chk($sformatf("tbl[%0d] out_zero", i), 32'(out_zero), 32'(tbl[i].ez));
`endif
            end
        end

        // streaming: 8 back-to-back, one output per cycle with 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), (i % 2 == 0) ? 2'b01 : 2'b11, 3'(i), 1'b1, 1'b0);
            step();
            chk($sformatf("stream[%0d] out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream[%0d] out_result", i), 32'(out_result), 32'h1000 + 32'(i));
            chk($sformatf("stream[%0d] out_rd", i), 32'(out_rd), 32'(i));
            chk($sformatf("stream[%0d] in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b1, 1'b0);
        step();
        chk("stream drained", 32'(out_valid), 32'd0);

        // reset mid-transfer with both entries full
        drive(1'b1, 16'hBEEF, 2'b10, 3'd2, 1'b0, 1'b0);
        step();
        step();
        chk("pre-reset full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd1);
        chk("async reset illegal_cnt", 32'(illegal_cnt), 32'd0);
        model_reset();
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // saturation: 300 illegal accepts
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'($urandom), 2'b10, 3'($urandom), 1'b1, 1'b0);
            step();
        end
        chk("saturated illegal_cnt", 32'(illegal_cnt), 32'd255);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0,
                  (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom),
                  2'($urandom),
                  3'($urandom),
                  ($urandom % 3) != 0,
                  ($urandom % 25) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
